// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and the stall controller.
// The datapath side (master) reports hazards; the controller side (slave) returns enables/clears.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             load_use_D;
  logic             branch_taken_D;
  logic             imem_ready;
  logic             dmem_busy_M;
  logic             cnt_clr;
  logic             EN_PC;
  logic             EN_FD;
  logic             CLR_FD;
  logic             EN_DE;
  logic             CLR_DE;
  logic             EN_EM;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             timeout_err;

  modport master (
    output load_use_D, branch_taken_D, imem_ready, dmem_busy_M, cnt_clr,
    input  EN_PC, EN_FD, CLR_FD, EN_DE, CLR_DE, EN_EM,
    input  state_o, stall_cnt, flush_cnt, timeout_err
  );

  modport slave (
    input  load_use_D, branch_taken_D, imem_ready, dmem_busy_M, cnt_clr,
    output EN_PC, EN_FD, CLR_FD, EN_DE, CLR_DE, EN_EM,
    output state_o, stall_cnt, flush_cnt, timeout_err
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Five-stage pipeline hazard controller: prioritised stall/flush classification per cycle,
// registered state, wait-timeout watchdog and saturating stall/flush performance counters.
module hazard_stall_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_controller_if.slave hz
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    IMEM_WAIT  = 3'd2,
    DMEM_WAIT  = 3'd3,
    FLUSH      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;

  logic en_pc, en_fd, clr_fd, en_de, clr_de, en_em;

  // Cycle classification; the class also names the next state.
  always_comb begin
    en_pc   = 1'b1;
    en_fd   = 1'b1;
    clr_fd  = 1'b0;
    en_de   = 1'b1;
    clr_de  = 1'b0;
    en_em   = 1'b1;
    state_d = RUN;
    if (hz.dmem_busy_M) begin
      en_pc   = 1'b0;
      en_fd   = 1'b0;
      en_de   = 1'b0;
      en_em   = 1'b0;
      state_d = DMEM_WAIT;
    end else if (hz.load_use_D && state_q != LOAD_STALL) begin
      // Hold PC/FD, bubble into DE; the taken branch is re-presented next cycle.
      en_pc   = 1'b0;
      en_fd   = 1'b0;
      clr_de  = 1'b1;
      state_d = LOAD_STALL;
    end else if (hz.branch_taken_D) begin
      clr_fd  = 1'b1;
      state_d = FLUSH;
    end else if (!hz.imem_ready) begin
      en_pc   = 1'b0;
      clr_fd  = 1'b1;
      state_d = IMEM_WAIT;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (state_d == IMEM_WAIT || state_d == DMEM_WAIT) begin
      if (state_d != state_q)
        wait_cnt_d = WAIT_W'(1);
      else if (wait_cnt_q != WAIT_W'(MAX_WAIT))
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      else
        wait_cnt_d = wait_cnt_q;
    end
  end

  // Sticky: once the wait run hits the limit, only reset clears it.
  assign timeout_d = timeout_q | (wait_cnt_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!en_pc && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (state_d == FLUSH && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hz.EN_PC       = en_pc;
  assign hz.EN_FD       = en_fd;
  assign hz.CLR_FD      = clr_fd;
  assign hz.EN_DE       = en_de;
  assign hz.CLR_DE      = clr_de;
  assign hz.EN_EM       = en_em;
  assign hz.state_o     = state_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
  assign hz.timeout_err = timeout_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: per-cycle control/state expectations queued
// at drive time and retired after the clock edge, plus counter/timeout spot checks.
module tb_hazard_stall_controller;

  localparam logic [5:0] C_RUN   = 6'b110101;
  localparam logic [5:0] C_DMEM  = 6'b000000;
  localparam logic [5:0] C_LOAD  = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111101;
  localparam logic [5:0] C_IMEM  = 6'b011101;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_stall_controller_if #(.CNT_W(4)) hz();

  hazard_stall_controller #(.MAX_WAIT(64), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] ctrl_obs;
  assign ctrl_obs = {hz.EN_PC, hz.EN_FD, hz.CLR_FD, hz.EN_DE, hz.CLR_DE, hz.EN_EM};

  typedef struct {
    string      tag;
    logic [5:0] ctrl;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational controls, then the new state.
  task automatic step(input string tag, input logic lu, input logic br, input logic ir,
                      input logic db, input logic clr,
                      input logic [5:0] ec, input logic [2:0] es);
    exp_t e;
    @(negedge clk);
    hz.load_use_D     = lu;
    hz.branch_taken_D = br;
    hz.imem_ready     = ir;
    hz.dmem_busy_M    = db;
    hz.cnt_clr        = clr;
    e.tag  = tag;
    e.ctrl = ec;
    e.st   = es;
    sb.push_back(e);
    #1;
    chk({tag, "_ctrl"}, 32'(ctrl_obs), 32'(sb[0].ctrl));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_state"}, 32'(hz.state_o), 32'(e.st));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    hz.load_use_D     = 1'b0;
    hz.branch_taken_D = 1'b0;
    hz.imem_ready     = 1'b1;
    hz.dmem_busy_M    = 1'b0;
    hz.cnt_clr        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(hz.state_o),     32'd0);
    chk("rst_stall",   32'(hz.stall_cnt),   32'd0);
    chk("rst_flush",   32'(hz.flush_cnt),   32'd0);
    chk("rst_timeout", 32'(hz.timeout_err), 32'd0);
    chk("rst_ctrl",    32'(ctrl_obs),       32'(C_RUN));
    @(negedge clk);
    rst = 1'b0;

    // Load-use held three cycles: stall, forced progress, stall
    step("lu1", 1, 0, 1, 0, 0, C_LOAD, 3'd1);
    step("lu2", 1, 0, 1, 0, 0, C_RUN,  3'd0);
    step("lu3", 1, 0, 1, 0, 0, C_LOAD, 3'd1);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 32'd2);
    step("lu_idle", 0, 0, 1, 0, 0, C_RUN, 3'd0);

    // dmem busy dominates everything; load stall comes before the branch on release
    step("db1", 1, 1, 1, 1, 0, C_DMEM,  3'd3);
    step("db2", 1, 1, 1, 1, 0, C_DMEM,  3'd3);
    step("db_rel_lu", 1, 1, 1, 0, 0, C_LOAD,  3'd1);
    step("db_rel_br", 1, 1, 1, 0, 0, C_FLUSH, 3'd4);
    chk("db_stall_cnt", 32'(hz.stall_cnt), 32'd5);
    chk("db_flush_cnt", 32'(hz.flush_cnt), 32'd1);

    step("clr", 0, 0, 1, 0, 1, C_RUN, 3'd0);
    chk("clr_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("clr_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // Branch wins over imem miss and does not stall
    step("br_imiss", 0, 1, 0, 0, 0, C_FLUSH, 3'd4);
    chk("br_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    step("br_idle", 0, 0, 1, 0, 0, C_RUN, 3'd0);

    // 64-cycle imem wait -> sticky timeout one cycle later
    for (int i = 0; i < 64; i++) begin
      step("imiss", 0, 0, 0, 0, 0, C_IMEM, 3'd2);
      if (i == 62) chk("to_before_63", 32'(hz.timeout_err), 32'd0);
    end
    chk("to_at_64", 32'(hz.timeout_err), 32'd0);
    chk("imiss_stall_sat", 32'(hz.stall_cnt), 32'd15);
    step("imiss_rel", 0, 0, 1, 0, 0, C_RUN, 3'd0);
    chk("to_set", 32'(hz.timeout_err), 32'd1);
    step("to_hold", 0, 0, 1, 0, 0, C_RUN, 3'd0);
    chk("to_sticky", 32'(hz.timeout_err), 32'd1);

    // Saturation from zero over 20 stall cycles, then clear beats increment
    step("sat_clr", 0, 0, 1, 0, 1, C_RUN, 3'd0);
    chk("sat_clr_stall", 32'(hz.stall_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step("sat_db", 0, 0, 1, 1, 0, C_DMEM, 3'd3);
      if (i == 14) chk("sat_at_15", 32'(hz.stall_cnt), 32'd15);
    end
    chk("sat_hold", 32'(hz.stall_cnt), 32'd15);
    step("sat_clr_stall", 0, 0, 1, 1, 1, C_DMEM, 3'd3);
    chk("clr_over_inc", 32'(hz.stall_cnt), 32'd0);

    // Async reset mid-cycle during DMEM_WAIT
    step("pre_br", 0, 1, 1, 0, 0, C_FLUSH, 3'd4);
    step("pre_db", 0, 0, 1, 1, 0, C_DMEM,  3'd3);
    chk("pre_rst_stall", 32'(hz.stall_cnt), 32'd1);
    chk("pre_rst_flush", 32'(hz.flush_cnt), 32'd1);
    chk("pre_rst_to",    32'(hz.timeout_err), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(hz.state_o),     32'd0);
    chk("arst_stall", 32'(hz.stall_cnt),   32'd0);
    chk("arst_flush", 32'(hz.flush_cnt),   32'd0);
    chk("arst_to",    32'(hz.timeout_err), 32'd0);
    chk("arst_ctrl",  32'(ctrl_obs),       32'(C_DMEM));
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 0, 0, 1, 0, 0, C_RUN, 3'd0);
    chk("post_rst_to", 32'(hz.timeout_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001: Parameter MAX_WAIT, default 64: consecutive wait cycles at which timeout_err sets.
REQ-002: Parameter CNT_W, default 16: width of performance counters.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: load_use_D  input  1  decode instruction needs the result of a load still in execute.
REQ-006: branch_taken_D  input  1  branch/jump resolved taken in decode; PC mux selects target.
REQ-007: imem_ready  input  1  instruction memory returns a valid instruction this cycle.
REQ-008: dmem_busy_M  input  1  multi-cycle data memory access in progress in memory stage.
REQ-009: cnt_clr  input  1  synchronous clear of stall_cnt and flush_cnt.
REQ-010: EN_PC  output  1  PC register enable.
REQ-011: EN_FD, CLR_FD  output  1 each  fetch/decode register enable and clear.
REQ-012: EN_DE, CLR_DE  output  1 each  decode/execute register enable and clear.
REQ-013: EN_EM  output  1  enable for execute/memory and memory/writeback registers.
REQ-014: state_o  output  3  registered FSM state.
REQ-015: stall_cnt, flush_cnt  output  CNT_W each  saturating performance counters.
REQ-016: timeout_err  output  1  sticky wait-timeout flag.

Function
REQ-017: Enable/clear outputs SHALL be combinational from inputs and the state register, valid in the same cycle.
REQ-018: FSM states SHALL be RUN=0, LOAD_STALL=1, IMEM_WAIT=2, DMEM_WAIT=3, FLUSH=4; next state is the class of the current cycle per REQ-019..023.
REQ-019: Priority 1, dmem_busy_M=1: EN_PC=EN_FD=EN_DE=EN_EM=0, all CLR=0; next state DMEM_WAIT.
REQ-020: Priority 2, load_use_D=1 and state!=LOAD_STALL: EN_PC=EN_FD=0, CLR_DE=1, EN_DE=EN_EM=1, branch_taken_D ignored; next state LOAD_STALL.
REQ-021: When state==LOAD_STALL, load_use_D SHALL be ignored for that cycle (one-cycle stall maximum per hazard, forced forward progress).
REQ-022: Priority 3, branch_taken_D=1: EN_PC=1, CLR_FD=1, EN_DE=EN_EM=1, whatever imem_ready is; next state FLUSH.
REQ-023: Priority 4, imem_ready=0: EN_PC=0, CLR_FD=1, EN_DE=EN_EM=1; next state IMEM_WAIT.
REQ-024: Otherwise: all enables 1, all clears 0; next state RUN.
REQ-025: CLR and EN both high on one register SHALL mean clear (CLR dominates).
REQ-026: Wait counter (internal, width clog2(MAX_WAIT+1)) SHALL increment each cycle whose next state equals the current state and is IMEM_WAIT or DMEM_WAIT, and SHALL load 1 when entering either wait state and 0 on any other state.
REQ-027: timeout_err SHALL set in the cycle after the wait counter reaches MAX_WAIT and hold until reset; pipeline control is unaffected.
REQ-028: stall_cnt SHALL increment, saturating at all-ones, every cycle with EN_PC=0.
REQ-029: flush_cnt SHALL increment, saturating, every cycle classed FLUSH.
REQ-030: cnt_clr=1 SHALL zero both counters next edge; it overrides an increment in the same cycle.

Reset
REQ-031: While rst=1: state=RUN, wait counter=0, stall_cnt=flush_cnt=0, timeout_err=0; outputs follow REQ-024 unless inputs select otherwise.
REQ-032: Reset asserted mid-stall SHALL drop state to RUN immediately and asynchronously, so LOAD_STALL suppression is lost.

Verification
REQ-033: load_use_D held high 3 cycles from RUN -> EN_PC pattern 0,1,0; CLR_DE pattern 1,0,1; state_o 1,0,1; stall_cnt=2.
REQ-034: dmem_busy_M=1 with load_use_D=1 and branch_taken_D=1 -> all EN=0, all CLR=0, state_o=3; after release, load stall occurs first.
REQ-035: branch_taken_D=1 with imem_ready=0 -> EN_PC=1, CLR_FD=1, state_o=4, flush_cnt +1, stall_cnt unchanged.
REQ-036: imem_ready=0 for 64 cycles, MAX_WAIT=64 -> timeout_err=1 on the following cycle; it stays 1 after imem_ready=1 until rst.
REQ-037: Preload stall_cnt near saturation (CNT_W=4, 20 stall cycles) -> stall_cnt=15 and holds; cnt_clr with a stall in the same cycle -> 0.
REQ-038: rst pulse during DMEM_WAIT mid-cycle -> state_o=0 and counters=0 before the next clk edge.
